// File: rtl/fp16_op_scheduler.sv
// Shares one pipelined fp16 adder and one fp16 multiplier between two requesters:
// round-robin issue, in-flight tracking and credit-protected per-requester result queues.
module fp16_op_scheduler #(
    parameter int WORD_LENGHT = 16,
    parameter int LAT         = 3,
    parameter int TAG_W       = 4,
    parameter int RQ_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_op,
    input  logic [1:0]               req_mode,
    input  logic [2*WORD_LENGHT-1:0] req_a,
    input  logic [2*WORD_LENGHT-1:0] req_b,
    input  logic [2*TAG_W-1:0]       req_tag,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [2*WORD_LENGHT-1:0] rsp_data,
    output logic [2*TAG_W-1:0]       rsp_tag,
    output logic [1:0]               rsp_error,
    output logic                     dp_mode,
    output logic [WORD_LENGHT-1:0]   dp_a,
    output logic [WORD_LENGHT-1:0]   dp_b,
    input  logic [WORD_LENGHT-1:0]   dp_add_c,
    input  logic [WORD_LENGHT-1:0]   dp_mul_c,
    input  logic                     dp_mul_error
);

    localparam int PW = $clog2(RQ_DEPTH);
    localparam int CW = $clog2(RQ_DEPTH + 1);

    logic [CW-1:0]          r_cred [2];
    logic                   r_ptr;
    logic [1:0]             w_elig;
    logic [1:0]             w_grant;
    logic                   w_issue;
    logic                   w_gid;
    logic                   w_sel_op;
    logic                   w_sel_mode;
    logic [WORD_LENGHT-1:0] w_sel_a;
    logic [WORD_LENGHT-1:0] w_sel_b;
    logic [TAG_W-1:0]       w_sel_tag;

    always_comb begin
        w_elig[0] = req_valid[0] && (r_cred[0] != '0);
        w_elig[1] = req_valid[1] && (r_cred[1] != '0);
        w_grant   = 2'b00;
        if (!rst) begin
            if (w_elig == 2'b11) begin
                w_grant[r_ptr] = 1'b1;
            end else begin
                w_grant = w_elig;
            end
        end
    end

    assign w_issue    = |w_grant;
    assign w_gid      = w_grant[1];
    assign req_ready  = w_grant;
    assign w_sel_op   = w_gid ? req_op[1]   : req_op[0];
    assign w_sel_mode = w_gid ? req_mode[1] : req_mode[0];
    assign w_sel_a    = w_gid ? req_a[2*WORD_LENGHT-1:WORD_LENGHT] : req_a[WORD_LENGHT-1:0];
    assign w_sel_b    = w_gid ? req_b[2*WORD_LENGHT-1:WORD_LENGHT] : req_b[WORD_LENGHT-1:0];
    assign w_sel_tag  = w_gid ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

    // Issue stage: operand register shared by both units.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 1'b0;
            dp_a    <= '0;
            dp_b    <= '0;
            dp_mode <= 1'b0;
        end else if (w_issue) begin
            r_ptr   <= ~w_gid;
            dp_a    <= w_sel_a;
            dp_b    <= w_sel_b;
            dp_mode <= w_sel_mode;
        end
    end

    logic [LAT:0]     r_trk_vld;
    logic [LAT:0]     r_trk_id;
    logic [LAT:0]     r_trk_op;
    logic [TAG_W-1:0] r_trk_tag [LAT+1];

    // Tracker: stage LAT lines up with the unit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trk_vld <= '0;
        end else begin
            r_trk_vld <= {r_trk_vld[LAT-1:0], w_issue};
        end
    end

    always_ff @(posedge clk) begin
        r_trk_id     <= {r_trk_id[LAT-1:0], w_gid};
        r_trk_op     <= {r_trk_op[LAT-1:0], w_sel_op};
        r_trk_tag[0] <= w_sel_tag;
        for (int k = 1; k <= LAT; k++) begin
            r_trk_tag[k] <= r_trk_tag[k-1];
        end
    end

    logic                   w_cap;
    logic                   w_cap_id;
    logic [WORD_LENGHT-1:0] w_cap_data;
    logic                   w_cap_err;

    assign w_cap      = r_trk_vld[LAT];
    assign w_cap_id   = r_trk_id[LAT];
    assign w_cap_data = r_trk_op[LAT] ? dp_mul_c : dp_add_c;
    assign w_cap_err  = r_trk_op[LAT] & dp_mul_error;

    logic [WORD_LENGHT-1:0] r_q_data [2][RQ_DEPTH];
    logic [TAG_W-1:0]       r_q_tag  [2][RQ_DEPTH];
    logic                   r_q_err  [2][RQ_DEPTH];
    logic [PW-1:0]          r_wptr   [2];
    logic [PW-1:0]          r_rptr   [2];
    logic [CW-1:0]          r_cnt    [2];
    logic [1:0]             w_push;
    logic [1:0]             w_pop;

    always_comb begin
        w_push    = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = '0;
        rsp_tag   = '0;
        rsp_error = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_push[i] = w_cap && (w_cap_id == 1'(i));
            if (!rst && (r_cnt[i] != '0)) begin
                rsp_valid[i]                          = 1'b1;
                rsp_data[i*WORD_LENGHT +: WORD_LENGHT] = r_q_data[i][r_rptr[i]];
                rsp_tag[i*TAG_W +: TAG_W]             = r_q_tag[i][r_rptr[i]];
                rsp_error[i]                          = r_q_err[i][r_rptr[i]];
            end
        end
    end

    assign w_pop = rsp_valid & rsp_ready;

    // Capture / queue stage: credits count free result slots per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
                r_cred[i] <= CW'(RQ_DEPTH);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_cred[i] <= r_cred[i] - CW'(1);
                    2'b01:   r_cred[i] <= r_cred[i] + CW'(1);
                    default: r_cred[i] <= r_cred[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_q_data[i][r_wptr[i]] <= w_cap_data;
                r_q_tag[i][r_wptr[i]]  <= r_trk_tag[LAT];
                r_q_err[i][r_wptr[i]]  <= w_cap_err;
            end
        end
    end

endmodule
